// File: rtl/rc5_pkg.sv
// RC5 shared definitions: FSM state encoding, derived-width helpers and the
// nominal P/Q magic constants used when expanding a key table.
package rc5_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_S,
        ST_PRE_ADD,
        ST_XOR_A,
        ST_ROT_A,
        ST_ADD_A,
        ST_XOR_B,
        ST_ROT_B,
        ST_ADD_B,
        ST_ROUND_A,
        ST_ROUND_B,
        ST_DONE
    } state_t;

    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;
    localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
    localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

    // Number of key-table entries for r rounds.
    function automatic int rc5_t(input int r);
        return 2 * (r + 1);
    endfunction

    // Key-table address width.
    function automatic int rc5_t_length(input int r);
        return $clog2(rc5_t(r));
    endfunction

    // Rotate-amount width for a w-bit word.
    function automatic int rc5_rot_value(input int w);
        return $clog2(w);
    endfunction

    // Round-counter width (holds 1..r).
    function automatic int rc5_r_bit(input int r);
        return $clog2(r + 1);
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// Combinational left barrel rotator; only the low clog2(W) bits of the
// rotate amount exist, so the amount is implicitly taken mod W.
module rc5_rotl
    import rc5_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]                  iData,
    input  logic [rc5_rot_value(W)-1:0]   iRotate,
    output logic [W-1:0]                  oData
);

    localparam int ROT_VALUE = rc5_rot_value(W);

    // A zero rotate yields a right shift of W, which contributes nothing,
    // so the data passes through unchanged.
    logic [ROT_VALUE:0] right_shift;

    assign right_shift = (ROT_VALUE + 1)'(W) - {1'b0, iRotate};
    assign oData       = (iData << iRotate) | (iData >> right_shift);

endmodule

// File: rtl/rc5_encipher.sv
// RC5-W/R block encryptor: pre-whitening add then R rounds, reading the
// expanded key table S through two synchronous (1-cycle latency) ports.
// Build option: define RC5_ENC_FAST_ROUND_EN to collapse each half-round
// into a single state (latency 2+2R instead of 2+6R, same results).
module rc5_encipher
    import rc5_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iStart,
    input  logic [W-1:0]                  iA,
    input  logic [W-1:0]                  iB,
    output logic [rc5_t_length(R)-1:0]    oS_address1,
    output logic [rc5_t_length(R)-1:0]    oS_address2,
    input  logic [W-1:0]                  iS_sub_i1,
    input  logic [W-1:0]                  iS_sub_i2,
    output logic [W-1:0]                  oA_cipher,
    output logic [W-1:0]                  oB_cipher,
    output logic                          oDone
);

    localparam int ROT_VALUE = rc5_rot_value(W);
    localparam int T_LENGTH  = rc5_t_length(R);
    localparam int R_BIT     = rc5_r_bit(R);
    localparam logic [R_BIT-1:0] R_LAST = R_BIT'(R);

    state_t             state, state_next;
    logic [W-1:0]       a, b;
    logic [R_BIT-1:0]   round;
    logic               last_round;
    logic [W-1:0]       rot_a_in, rot_b_in, rot_a, rot_b;
    logic [T_LENGTH-1:0] addr1_adv, addr2_adv;

    assign oA_cipher  = a;
    assign oB_cipher  = b;
    assign last_round = (round == R_LAST);

    // Next even/odd key index for the following round (T_LENGTH = R_BIT+1).
    assign addr1_adv = {round, 1'b0} + T_LENGTH'(2);
    assign addr2_adv = {round, 1'b0} + T_LENGTH'(3);

`ifdef RC5_ENC_FAST_ROUND_EN
    assign rot_a_in = a ^ b;
    assign rot_b_in = b ^ a;
`else
    assign rot_a_in = a;
    assign rot_b_in = b;
`endif

    rc5_rotl #(.W(W)) u_rotl_a (
        .iData   (rot_a_in),
        .iRotate (b[ROT_VALUE-1:0]),
        .oData   (rot_a)
    );

    rc5_rotl #(.W(W)) u_rotl_b (
        .iData   (rot_b_in),
        .iRotate (a[ROT_VALUE-1:0]),
        .oData   (rot_b)
    );

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state sequencing of the whitening add and the round states.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (iStart) state_next = ST_WAIT_S;
            ST_WAIT_S:  state_next = ST_PRE_ADD;
`ifdef RC5_ENC_FAST_ROUND_EN
            ST_PRE_ADD: state_next = ST_ROUND_A;
            ST_ROUND_A: state_next = ST_ROUND_B;
            ST_ROUND_B: state_next = last_round ? ST_DONE : ST_ROUND_A;
`else
            ST_PRE_ADD: state_next = ST_XOR_A;
            ST_XOR_A:   state_next = ST_ROT_A;
            ST_ROT_A:   state_next = ST_ADD_A;
            ST_ADD_A:   state_next = ST_XOR_B;
            ST_XOR_B:   state_next = ST_ROT_B;
            ST_ROT_B:   state_next = ST_ADD_B;
            ST_ADD_B:   state_next = last_round ? ST_DONE : ST_XOR_A;
`endif
            ST_DONE:    if (!iStart) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Datapath, key-table addressing and done flag; addresses run one state
    // ahead of their use to cover the RAM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a           <= '0;
            b           <= '0;
            oS_address1 <= '0;
            oS_address2 <= T_LENGTH'(1);
            round       <= R_BIT'(1);
            oDone       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        a           <= iA;
                        b           <= iB;
                        oS_address1 <= '0;
                        oS_address2 <= T_LENGTH'(1);
                        round       <= R_BIT'(1);
                    end
                end
                ST_WAIT_S: begin
                    oS_address1 <= T_LENGTH'(2);
                    oS_address2 <= T_LENGTH'(3);
                end
                ST_PRE_ADD: begin
                    a <= a + iS_sub_i1;
                    b <= b + iS_sub_i2;
                end
`ifdef RC5_ENC_FAST_ROUND_EN
                ST_ROUND_A: begin
                    a <= rot_a + iS_sub_i1;
                    if (!last_round) oS_address1 <= addr1_adv;
                end
                ST_ROUND_B: begin
                    b <= rot_b + iS_sub_i2;
                    if (!last_round) begin
                        oS_address2 <= addr2_adv;
                        round       <= round + R_BIT'(1);
                    end else begin
                        oDone <= 1'b1;
                    end
                end
`else
                ST_XOR_A: a <= a ^ b;
                ST_ROT_A: a <= rot_a;
                ST_ADD_A: begin
                    a <= a + iS_sub_i1;
                    if (!last_round) oS_address1 <= addr1_adv;
                end
                ST_XOR_B: b <= b ^ a;
                ST_ROT_B: b <= rot_b;
                ST_ADD_B: begin
                    b <= b + iS_sub_i2;
                    if (!last_round) begin
                        oS_address2 <= addr2_adv;
                        round       <= round + R_BIT'(1);
                    end else begin
                        oDone <= 1'b1;
                    end
                end
`endif
                ST_DONE: if (!iStart) oDone <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
